router_egress_sched: RTL and testbench

Round-robin egress scheduler for the 1x3 router's three output ports. It drains whole packets from the three output FIFOs by driving their read enables, and serialises them onto one byte-wide egress link with start/end-of-packet framing. A granted port is held until its packet, including the parity byte, has been fully read. It sits between the router's data_out/valid_out/read_enb ports and a single downstream consumer.

---
 rtl/router_egress_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_router_egress_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_egress_sched.sv
// Round-robin egress scheduler for the 1x3 router.
// Drains whole packets (header, payload, parity) from three port FIFOs and
// serialises them onto one byte-wide link with sop/eop framing. A granted
// port keeps ownership until its parity byte has been read.
module router_egress_sched (
  input  logic       clock,
  input  logic       resetn,
  input  logic       valid_out_0,
  input  logic       valid_out_1,
  input  logic       valid_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  input  logic       link_ready,
  output logic [7:0] link_data,
  output logic       link_valid,
  output logic       link_sop,
  output logic       link_eop,
  output logic [2:0] grant,
  output logic       sched_busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_HDR   = 3'd1,
    WAIT_HDR = 3'd2,
    XFER     = 3'd3,
    LAST     = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  curPort_q;
  logic [1:0]  lastPort_q;
  logic [6:0]  rem_q;

  // Read-to-link pipeline: a read issued in cycle N returns data in N+1,
  // which is registered onto the link for cycle N+2.
  logic        pendRd_q;
  logic        pendSop_q;
  logic        pendEop_q;
  logic [1:0]  pendPort_q;

  logic [7:0]  linkData_q;
  logic        linkValid_q;
  logic        linkSop_q;
  logic        linkEop_q;

  logic [2:0]  validVec;
  logic        curValid;
  logic [7:0]  curData;
  logic [7:0]  pendData;
  logic        pickValid;
  logic [1:0]  pickPort;
  logic [1:0]  cand1;
  logic [1:0]  cand2;
  logic [1:0]  cand3;
  logic        issueRd_d;
  logic        issueSop_d;
  logic        issueEop_d;
  logic [6:0]  remLoad_d;

  function automatic logic [1:0] nextPort(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic portValid(input logic [2:0] v, input logic [1:0] p);
    logic r;
    case (p)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] p);
    logic [2:0] r;
    case (p)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign validVec = {valid_out_2, valid_out_1, valid_out_0};

  // Select the owning port's FIFO status/data and the data of the port read last cycle.
  always_comb begin
    curValid = 1'b0;
    curData  = 8'h00;
    pendData = 8'h00;
    case (curPort_q)
      2'd0:    begin curValid = valid_out_0; curData = data_out_0; end
      2'd1:    begin curValid = valid_out_1; curData = data_out_1; end
      2'd2:    begin curValid = valid_out_2; curData = data_out_2; end
      default: begin curValid = 1'b0; curData = 8'h00; end
    endcase
    case (pendPort_q)
      2'd0:    pendData = data_out_0;
      2'd1:    pendData = data_out_1;
      2'd2:    pendData = data_out_2;
      default: pendData = 8'h00;
    endcase
  end

  // Round-robin search starting one past the last port that finished a packet.
  always_comb begin
    cand1     = nextPort(lastPort_q);
    cand2     = nextPort(cand1);
    cand3     = nextPort(cand2);
    pickValid = 1'b1;
    pickPort  = cand1;
    if (portValid(validVec, cand1)) begin
      pickPort = cand1;
    end else if (portValid(validVec, cand2)) begin
      pickPort = cand2;
    end else if (portValid(validVec, cand3)) begin
      pickPort = cand3;
    end else begin
      pickValid = 1'b0;
    end
  end

  // Read strobe is combinational so a stalled FIFO or link costs no extra cycle.
  always_comb begin
    issueRd_d  = 1'b0;
    issueSop_d = 1'b0;
    issueEop_d = 1'b0;
    remLoad_d  = 7'(curData >> 2) + 7'd1;
    if (state_q == RD_HDR) begin
      issueRd_d  = link_ready & curValid;
      issueSop_d = issueRd_d;
    end else if (state_q == XFER) begin
      issueRd_d  = link_ready & curValid & (rem_q != 7'd0);
      issueEop_d = issueRd_d & (rem_q == 7'd1);
    end
  end

  assign read_enb_0 = issueRd_d & (curPort_q == 2'd0);
  assign read_enb_1 = issueRd_d & (curPort_q == 2'd1);
  assign read_enb_2 = issueRd_d & (curPort_q == 2'd2);

  // Packet FSM: arbitrate, fetch header, count down payload plus parity, release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      curPort_q  <= 2'd0;
      lastPort_q <= 2'd2;
      rem_q      <= 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            curPort_q <= pickPort;
            grant_q   <= oneHot(pickPort);
            state_q   <= RD_HDR;
          end
        end
        RD_HDR: begin
          if (issueRd_d) state_q <= WAIT_HDR;
        end
        WAIT_HDR: begin
          rem_q   <= remLoad_d;
          state_q <= XFER;
        end
        XFER: begin
          if (issueRd_d) begin
            rem_q <= rem_q - 7'd1;
            if (rem_q == 7'd1) state_q <= LAST;
          end
        end
        LAST: begin
          lastPort_q <= curPort_q;
          grant_q    <= 3'b000;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Remember each issued read and its framing, then register the returned byte onto the link.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pendRd_q    <= 1'b0;
      pendSop_q   <= 1'b0;
      pendEop_q   <= 1'b0;
      pendPort_q  <= 2'd0;
      linkData_q  <= 8'h00;
      linkValid_q <= 1'b0;
      linkSop_q   <= 1'b0;
      linkEop_q   <= 1'b0;
    end else begin
      pendRd_q    <= issueRd_d;
      pendSop_q   <= issueSop_d;
      pendEop_q   <= issueEop_d;
      pendPort_q  <= curPort_q;
      linkValid_q <= pendRd_q;
      linkSop_q   <= pendRd_q & pendSop_q;
      linkEop_q   <= pendRd_q & pendEop_q;
      if (pendRd_q) linkData_q <= pendData;
    end
  end

  assign link_data  = linkData_q;
  assign link_valid = linkValid_q;
  assign link_sop   = linkSop_q;
  assign link_eop   = linkEop_q;
  assign grant      = grant_q;
  assign sched_busy = (state_q != IDLE);

endmodule

// File: tb/tb_router_egress_sched.sv
// Bench for router_egress_sched: three model FIFOs feed the scheduler, a
// monitor captures link bytes, and expected streams come from the packets pushed.
module tb_router_egress_sched;

  logic       clock = 1'b0;
  logic       resetn;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       link_ready;
  logic [7:0] link_data;
  logic       link_valid, link_sop, link_eop;
  logic [2:0] grant;
  logic       sched_busy;

  router_egress_sched dut (
    .clock(clock), .resetn(resetn),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .link_ready(link_ready), .link_data(link_data), .link_valid(link_valid),
    .link_sop(link_sop), .link_eop(link_eop), .grant(grant), .sched_busy(sched_busy)
  );

  always #5 clock = ~clock;

  // Model FIFOs: whole packets are written by the stimulus, popped on read_enb.
  logic [7:0] mem [3][256];
  int         wrPtr [3] = '{0, 0, 0};
  int         rdPtr [3] = '{0, 0, 0};
  logic [7:0] dOut  [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] stallMask = 3'b000;
  logic [2:0] flushReq  = 3'b000;
  logic [2:0] rdEn;
  int         cyc = 0;

  assign rdEn        = {read_enb_2, read_enb_1, read_enb_0};
  assign valid_out_0 = (rdPtr[0] != wrPtr[0]) && !stallMask[0];
  assign valid_out_1 = (rdPtr[1] != wrPtr[1]) && !stallMask[1];
  assign valid_out_2 = (rdPtr[2] != wrPtr[2]) && !stallMask[2];
  assign data_out_0  = dOut[0];
  assign data_out_1  = dOut[1];
  assign data_out_2  = dOut[2];

  // FIFO pop: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (flushReq[k]) begin
        rdPtr[k] <= wrPtr[k];
      end else if (rdEn[k]) begin
        dOut[k]  <= mem[k][rdPtr[k] % 256];
        rdPtr[k] <= rdPtr[k] + 1;
      end
    end
  end

  // Link monitor and protocol watchers.
  logic [9:0] actQ [$];
  int         actCycQ [$];
  logic [2:0] grantQ [$];
  logic [2:0] prevGrant = 3'b000;
  int         readOverlap = 0;
  int         grantSkip = 0;
  int         notReadyReads = 0;
  int         readCount [3] = '{0, 0, 0};

  always @(negedge clock) begin
    if (link_valid) begin
      actQ.push_back({link_sop, link_eop, link_data});
      actCycQ.push_back(cyc);
    end
    if ((int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2)) > 1) readOverlap++;
    if (!link_ready && (rdEn != 3'b000)) notReadyReads++;
    for (int k = 0; k < 3; k++) if (rdEn[k]) readCount[k]++;
    if (grant != 3'b000 && prevGrant == 3'b000) grantQ.push_back(grant);
    if (grant != 3'b000 && prevGrant != 3'b000 && grant != prevGrant) grantSkip++;
    prevGrant = grant;
  end

  int         checkCount = 0;
  int         passCount = 0;
  logic [9:0] expQ [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write a complete packet into a port FIFO and append its expected link bytes.
  task automatic pushPacket(input int port, input int len, input logic [7:0] base);
    logic [7:0] b;
    logic [7:0] par;
    int         p;
    p   = wrPtr[port];
    b   = 8'((len << 2) | port);
    par = b;
    mem[port][p % 256] = b;
    expQ.push_back({2'b10, b});
    for (int i = 0; i < len; i++) begin
      b   = base + 8'(i);
      par = par ^ b;
      mem[port][(p + 1 + i) % 256] = b;
      expQ.push_back({2'b00, b});
    end
    mem[port][(p + 1 + len) % 256] = par;
    expQ.push_back({2'b01, par});
    wrPtr[port] = p + len + 2;
  endtask

  task automatic waitBytes(input int base, input int n, input int budget);
    int t = 0;
    while ((actQ.size() - base) < n && t < budget) begin
      @(posedge clock);
      t++;
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic compareStream(input string name, input int base);
    int n;
    n = actQ.size() - base;
    checkOutput({name, "_count"}, n, expQ.size());
    for (int i = 0; i < expQ.size() && (base + i) < actQ.size(); i++)
      checkOutput({name, "_byte"}, {22'd0, actQ[base + i]}, {22'd0, expQ[i]});
    expQ.delete();
  endtask

  typedef struct {
    logic [2:0] rd;
    logic [2:0] gnt;
    logic       busy;
    logic       lv;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [10];

  task automatic applyStimulus(input int c);
    checkOutput($sformatf("c%0d_read_enb", c), {29'd0, rdEn}, {29'd0, tbl[c].rd});
    checkOutput($sformatf("c%0d_grant", c), {29'd0, grant}, {29'd0, tbl[c].gnt});
    checkOutput($sformatf("c%0d_busy", c), {31'd0, sched_busy}, {31'd0, tbl[c].busy});
    checkOutput($sformatf("c%0d_link_flags", c), {29'd0, link_valid, link_sop, link_eop},
                {29'd0, tbl[c].lv, tbl[c].sop, tbl[c].eop});
    if (tbl[c].lv) checkOutput($sformatf("c%0d_link_data", c), {24'd0, link_data}, {24'd0, tbl[c].data});
  endtask

  initial begin
    int base;
    int gBase;
    int start;
    int rc;
    int nr;
    int eops;

    // Port 1, L=3, full rate: cycle-by-cycle expectations.
    tbl[0] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{3'b010, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0D};
    tbl[4] = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{3'b010, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1};
    tbl[6] = '{3'b010, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA2};
    tbl[7] = '{3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA3};
    tbl[8] = '{3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAD};
    tbl[9] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    resetn     = 1'b0;
    link_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_read_enb", {29'd0, rdEn}, 32'd0);
    checkOutput("reset_grant", {29'd0, grant}, 32'd0);
    checkOutput("reset_busy", {31'd0, sched_busy}, 32'd0);
    checkOutput("reset_link", {21'd0, link_valid, link_sop, link_eop, link_data}, 32'd0);
    resetn = 1'b1;

    // Single packet table.
    @(posedge clock);
    #1;
    pushPacket(1, 3, 8'hA1);
    for (int c = 0; c < 10; c++) begin
      #1;
      applyStimulus(c);
      @(posedge clock);
      #1;
    end
    expQ.delete();

    // Three ports pending from reset: order 0,1,2,0.
    resetn = 1'b0;
    #1;
    base  = actQ.size();
    gBase = grantQ.size();
    pushPacket(0, 2, 8'h10);
    pushPacket(1, 2, 8'h20);
    pushPacket(2, 2, 8'h30);
    pushPacket(0, 2, 8'h40);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    waitBytes(base, 16, 300);
    compareStream("rr", base);
    checkOutput("rr_grant_count", grantQ.size() - gBase, 4);
    if (grantQ.size() - gBase >= 4) begin
      checkOutput("rr_grant0", {29'd0, grantQ[gBase]},     32'd1);
      checkOutput("rr_grant1", {29'd0, grantQ[gBase + 1]}, 32'd2);
      checkOutput("rr_grant2", {29'd0, grantQ[gBase + 2]}, 32'd4);
      checkOutput("rr_grant3", {29'd0, grantQ[gBase + 3]}, 32'd1);
    end

    // L=0 on port 2: two reads, sop at cycle 3, eop at cycle 5.
    @(posedge clock);
    #1;
    base  = actQ.size();
    start = cyc;
    rc    = readCount[2];
    pushPacket(2, 0, 8'h00);
    waitBytes(base, 2, 100);
    checkOutput("l0_reads", readCount[2] - rc, 2);
    if (actQ.size() - base >= 2) begin
      checkOutput("l0_sop_cycle", actCycQ[base] - start, 3);
      checkOutput("l0_eop_cycle", actCycQ[base + 1] - start, 5);
    end
    compareStream("l0", base);

    // Backpressure: link_ready low for cycles 5..8 of an L=5 packet.
    @(posedge clock);
    #1;
    base = actQ.size();
    rc   = readCount[0];
    nr   = notReadyReads;
    pushPacket(0, 5, 8'h50);
    repeat (5) @(posedge clock);
    #1;
    link_ready = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    link_ready = 1'b1;
    waitBytes(base, 7, 100);
    checkOutput("bp_reads_while_low", notReadyReads - nr, 0);
    checkOutput("bp_reads", readCount[0] - rc, 7);
    compareStream("bp", base);

    // FIFO empties for 3 cycles mid-packet: grant held, no reads.
    @(posedge clock);
    #1;
    base = actQ.size();
    pushPacket(0, 4, 8'h70);
    repeat (4) @(posedge clock);
    #1;
    stallMask = 3'b001;
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput("stall_grant", {29'd0, grant}, 32'd1);
      checkOutput("stall_read_enb", {29'd0, rdEn}, 32'd0);
      @(posedge clock);
      #1;
    end
    stallMask = 3'b000;
    waitBytes(base, 6, 100);
    compareStream("stall", base);

    // Reset during XFER, then port 0 wins first.
    @(posedge clock);
    #1;
    base = actQ.size();
    pushPacket(1, 6, 8'h90);
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("mid_reset_read_enb", {29'd0, rdEn}, 32'd0);
    checkOutput("mid_reset_grant", {29'd0, grant}, 32'd0);
    checkOutput("mid_reset_busy", {31'd0, sched_busy}, 32'd0);
    checkOutput("mid_reset_link", {21'd0, link_valid, link_sop, link_eop, link_data}, 32'd0);
    eops = 0;
    for (int i = base; i < actQ.size(); i++) if (actQ[i][8]) eops++;
    checkOutput("mid_reset_no_eop", eops, 0);
    expQ.delete();
    flushReq = 3'b111;
    @(posedge clock);
    #1;
    flushReq = 3'b000;
    base  = actQ.size();
    gBase = grantQ.size();
    pushPacket(0, 1, 8'hB0);
    pushPacket(1, 1, 8'hC0);
    pushPacket(2, 1, 8'hD0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post_reset_grant", {29'd0, grant}, 32'd1);
    waitBytes(base, 9, 200);
    compareStream("post_reset", base);
    checkOutput("post_reset_grant_count", grantQ.size() - gBase, 3);
    if (grantQ.size() - gBase >= 3) begin
      checkOutput("post_reset_grant1", {29'd0, grantQ[gBase + 1]}, 32'd2);
      checkOutput("post_reset_grant2", {29'd0, grantQ[gBase + 2]}, 32'd4);
    end

    checkOutput("read_enb_onehot", readOverlap, 0);
    checkOutput("grant_via_idle", grantSkip, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
